mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the IF fetch port and the MEM
// load/store port. Only one transaction is in flight at a time. Each
// transaction waits a fixed read latency, then the owner gets a one-cycle
// rvalid pulse together with registered read data.
//
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   if_req_i/if_addr_i               fetch request (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o/if_rdata_o  fetch grant, response pulse, data
//   ls_req_i/ls_we_i/ls_be_i/
//   ls_addr_i/ls_wdata_i             load/store request (held until ls_gnt_o)
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o  load/store grant, completion, load data
//   mem_req_o/mem_we_o/mem_be_o/
//   mem_addr_o/mem_wdata_o           memory strobe, driven from the winner
//   mem_rdata_i                      memory read data, valid Lat cycles after mem_req_o
//   stall_if_o/stall_ls_o            freeze the requesting pipeline stage
//   busy_o                           a transaction is in WAIT or RESP
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to add the fetch starvation
// guard. After StarveMax lost contentions, fetch wins the next one.
module mem_port_arbiter #(
  parameter int Width     = 32,
  parameter int AddrW     = 13,
  parameter int Lat       = 2,
  parameter int StarveMax = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [AddrW-1:0] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [Width-1:0] if_rdata_o,
  input  logic             ls_req_i,
  input  logic             ls_we_i,
  input  logic [3:0]       ls_be_i,
  input  logic [AddrW-1:0] ls_addr_i,
  input  logic [Width-1:0] ls_wdata_i,
  output logic             ls_gnt_o,
  output logic             ls_rvalid_o,
  output logic [Width-1:0] ls_rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [3:0]       mem_be_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  input  logic [Width-1:0] mem_rdata_i,
  output logic             stall_if_o,
  output logic             stall_ls_o,
  output logic             busy_o
);
  localparam int CntW = $clog2(Lat + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             owner_q, owner_d;   // 0 = IF, 1 = LS
  logic             we_q, we_d;
  logic [Width-1:0] if_rdata_q, if_rdata_d;
  logic [Width-1:0] ls_rdata_q, ls_rdata_d;
  logic             arb_en, gnt_if, gnt_ls, force_if;

  // Arbitration runs in IDLE and RESP. A reset cycle never grants, because
  // that transaction would be dropped anyway.
  assign arb_en = ~rst_i & ((state_q == IDLE) | (state_q == RESP));
  // LS normally wins because it holds the older instruction.
  assign gnt_ls = arb_en & ls_req_i & ~(force_if & if_req_i);
  assign gnt_if = arb_en & if_req_i & ~gnt_ls;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int StW = $clog2(StarveMax + 1);
  logic [StW-1:0] starve_q, starve_d;

  assign force_if = (starve_q >= StW'(StarveMax));

  // Counts contentions that fetch lost. It saturates at the threshold and
  // clears on any fetch grant.
  always_comb begin
    starve_d = starve_q;
    if (gnt_if)
      starve_d = '0;
    else if (gnt_ls && if_req_i && (starve_q < StW'(StarveMax)))
      starve_d = starve_q + StW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (gnt_if | gnt_ls) begin
          owner_d = gnt_ls;
          we_d    = gnt_ls & ls_we_i;
          cnt_d   = CntW'(1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == CntW'(Lat)) begin
          state_d = RESP;
          if (owner_q) ls_rdata_d = we_q ? '0 : mem_rdata_i;
          else         if_rdata_d = mem_rdata_i;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_gnt_o    = gnt_if;
  assign ls_gnt_o    = gnt_ls;
  assign mem_req_o   = gnt_if | gnt_ls;
  assign mem_we_o    = gnt_ls & ls_we_i;
  // Fetch is always a full-word read.
  assign mem_be_o    = gnt_ls ? ls_be_i   : (gnt_if ? 4'hF : 4'h0);
  assign mem_addr_o  = gnt_ls ? ls_addr_i : (gnt_if ? if_addr_i : '0);
  assign mem_wdata_o = gnt_ls ? ls_wdata_i : '0;

  assign if_rvalid_o = (state_q == RESP) & ~owner_q;
  assign ls_rvalid_o = (state_q == RESP) &  owner_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

  assign stall_if_o  = (if_req_i & ~gnt_if) | (~owner_q & (state_q == WAIT));
  assign stall_ls_o  = (ls_req_i & ~gnt_ls) | ( owner_q & (state_q == WAIT));
  assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        if_req_i = 1'b0, ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [12:0] if_addr_i = '0, ls_addr_i = '0;
  logic [3:0]  ls_be_i = '0;
  logic [31:0] ls_wdata_i = '0, mem_rdata_i;

  // u0: Lat=2, u1: Lat=1. Both instances get the same inputs.
  logic        o0_if_gnt, o0_if_rv, o0_ls_gnt, o0_ls_rv, o0_req, o0_we, o0_sif, o0_sls, o0_busy;
  logic [31:0] o0_if_rd, o0_ls_rd, o0_wd;
  logic [3:0]  o0_be;
  logic [12:0] o0_addr;
  logic        o1_if_gnt, o1_if_rv, o1_ls_gnt, o1_ls_rv, o1_req, o1_we, o1_sif, o1_sls, o1_busy;
  logic [31:0] o1_if_rd, o1_ls_rd, o1_wd;
  logic [3:0]  o1_be;
  logic [12:0] o1_addr;

  mem_port_arbiter #(.Lat(2)) u0 (
    .clk_i(clk), .rst_i(rst_i), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(o0_if_gnt), .if_rvalid_o(o0_if_rv), .if_rdata_o(o0_if_rd),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(o0_ls_gnt), .ls_rvalid_o(o0_ls_rv), .ls_rdata_o(o0_ls_rd),
    .mem_req_o(o0_req), .mem_we_o(o0_we), .mem_be_o(o0_be), .mem_addr_o(o0_addr),
    .mem_wdata_o(o0_wd), .mem_rdata_i(mem_rdata_i), .stall_if_o(o0_sif), .stall_ls_o(o0_sls),
    .busy_o(o0_busy));

  mem_port_arbiter #(.Lat(1)) u1 (
    .clk_i(clk), .rst_i(rst_i), .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(o1_if_gnt), .if_rvalid_o(o1_if_rv), .if_rdata_o(o1_if_rd),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(o1_ls_gnt), .ls_rvalid_o(o1_ls_rv), .ls_rdata_o(o1_ls_rd),
    .mem_req_o(o1_req), .mem_we_o(o1_we), .mem_be_o(o1_be), .mem_addr_o(o1_addr),
    .mem_wdata_o(o1_wd), .mem_rdata_i(mem_rdata_i), .stall_if_o(o1_sif), .stall_ls_o(o1_sls),
    .busy_o(o1_busy));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc_n = 0;
  logic use1 = 1'b0;

  function automatic logic [31:0] memval(input logic [12:0] a);
    if (a == 13'h010) return 32'h00500093;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Memory model: read data is valid only in cycle T+Lat, and garbage otherwise.
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [12:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    v1 <= use1 ? (o1_req & ~o1_we) : (o0_req & ~o0_we);
    a1 <= use1 ? o1_addr : o0_addr;
    v2 <= v1;
    a2 <= a1;
  end
  always_comb begin
    mem_rdata_i = 32'hDEADBEEF;
    if (use1 && v1)  mem_rdata_i = memval(a1);
    if (!use1 && v2) mem_rdata_i = memval(a2);
  end

  typedef struct { logic ls; logic [31:0] data; int due; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop and compare on response. Push the expected result on grant.
  task automatic sb();
    logic gi, gl, rvi, rvl;
    logic [31:0] rdi, rdl;
    exp_t e;
    int lat;
    gi  = use1 ? o1_if_gnt : o0_if_gnt;  gl  = use1 ? o1_ls_gnt : o0_ls_gnt;
    rvi = use1 ? o1_if_rv  : o0_if_rv;   rvl = use1 ? o1_ls_rv  : o0_ls_rv;
    rdi = use1 ? o1_if_rd  : o0_if_rd;   rdl = use1 ? o1_ls_rd  : o0_ls_rd;
    lat = use1 ? 1 : 2;
    if (rvi | rvl) begin
      chk("rv_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rv_port", 32'(rvl), 32'(e.ls));
        chk("rv_data", rvl ? rdl : rdi, e.data);
        chk("rv_cycle", 32'(cyc_n), 32'(e.due));
      end
    end
    if (gi | gl) begin
      e.ls   = gl;
      e.data = (gl && ls_we_i) ? 32'h0 : memval(gl ? ls_addr_i : if_addr_i);
      e.due  = cyc_n + lat + 1;
      q.push_back(e);
    end
  endtask

  task automatic adv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); sb(); endtask

  initial begin
    // Reset state
    adv(); adv(); smp();
    chk("rst_busy", 32'(o0_busy), 0);       chk("rst_mem_req", 32'(o0_req), 0);
    chk("rst_if_rdata", o0_if_rd, 0);       chk("rst_stall_if", 32'(o0_sif), 0);
    adv(); rst_i = 1'b0;

    // Single fetch
    adv(); if_req_i = 1'b1; if_addr_i = 13'h010; smp();
    chk("f_if_gnt", 32'(o0_if_gnt), 1);  chk("f_ls_gnt", 32'(o0_ls_gnt), 0);
    chk("f_mem_req", 32'(o0_req), 1);    chk("f_mem_addr", 32'(o0_addr), 32'h010);
    chk("f_mem_we", 32'(o0_we), 0);      chk("f_busy_T", 32'(o0_busy), 0);
    adv(); if_req_i = 1'b0; smp();
    chk("f_busy_T1", 32'(o0_busy), 1);   chk("f_mem_req_wait", 32'(o0_req), 0);
    chk("f_stall_if_wait", 32'(o0_sif), 1);
    adv(); smp(); chk("f_busy_T2", 32'(o0_busy), 1);
    adv(); smp();
    chk("f_rvalid", 32'(o0_if_rv), 1);   chk("f_rdata", o0_if_rd, 32'h00500093);
    chk("f_busy_T3", 32'(o0_busy), 1);
    adv(); smp();
    chk("f_rvalid_pulse", 32'(o0_if_rv), 0); chk("f_rdata_hold", o0_if_rd, 32'h00500093);
    chk("f_idle", 32'(o0_busy), 0);

    // Simultaneous requests: ls wins
    adv(); if_req_i = 1'b1; if_addr_i = 13'h014; ls_req_i = 1'b1; ls_addr_i = 13'h800; smp();
    chk("c_ls_gnt", 32'(o0_ls_gnt), 1);  chk("c_if_gnt", 32'(o0_if_gnt), 0);
    chk("c_stall_if", 32'(o0_sif), 1);   chk("c_stall_ls", 32'(o0_sls), 0);
    chk("c_mem_addr", 32'(o0_addr), 32'h800);
    adv(); ls_req_i = 1'b0; smp();
    chk("c_stall_if_T1", 32'(o0_sif), 1); chk("c_stall_ls_T1", 32'(o0_sls), 1);
    adv(); smp(); chk("c_stall_if_T2", 32'(o0_sif), 1);
    adv(); smp();
    chk("c_ls_rvalid", 32'(o0_ls_rv), 1); chk("c_if_gnt_resp", 32'(o0_if_gnt), 1);
    chk("c_stall_if_resp", 32'(o0_sif), 0);
    adv(); if_req_i = 1'b0;
    repeat (3) begin smp(); adv(); end
    chk("c_drained", 32'(q.size()), 0);

    // Store byte
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'b0001; ls_wdata_i = 32'hAB; ls_addr_i = 13'h020; smp();
    chk("s_gnt", 32'(o0_ls_gnt), 1);  chk("s_mem_we", 32'(o0_we), 1);
    chk("s_mem_be", 32'(o0_be), 1);   chk("s_wdata", o0_wd, 32'hAB);
    adv(); ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0; smp();
    adv(); smp();
    adv(); smp();
    chk("s_rvalid", 32'(o0_ls_rv), 1); chk("s_rdata", o0_ls_rd, 0);
    chk("s_if_rdata_kept", o0_if_rd, memval(13'h014));
    chk("s_if_rvalid_quiet", 32'(o0_if_rv), 0);

    // Starvation: both ports request continuously
    adv(); if_req_i = 1'b1; if_addr_i = 13'h200; ls_req_i = 1'b1; ls_addr_i = 13'h100;
    for (int k = 1; k <= 6; k++) begin
      int w;
      logic exp_if;
      w = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (k == 5);
`else
      exp_if = 1'b0;
`endif
      smp();
      while (!(o0_if_gnt | o0_ls_gnt) && w < 8) begin adv(); smp(); w++; end
      chk("st_gnt_seen", 32'(o0_if_gnt | o0_ls_gnt), 1);
      chk("st_if_wins", 32'(o0_if_gnt), 32'(exp_if));
      adv();
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    repeat (4) begin smp(); adv(); end
    chk("st_drained", 32'(q.size()), 0);

    // Reset mid-transaction
    if_req_i = 1'b1; if_addr_i = 13'h010; smp();
    chk("r_gnt", 32'(o0_if_gnt), 1);
    adv(); if_req_i = 1'b0; rst_i = 1'b1; smp();
    adv(); rst_i = 1'b0; q.delete(); smp();
    chk("r_rvalid", 32'(o0_if_rv), 0);  chk("r_busy", 32'(o0_busy), 0);
    chk("r_mem_req", 32'(o0_req), 0);   chk("r_if_rdata", o0_if_rd, 0);
    chk("r_stall_if", 32'(o0_sif), 0);  chk("r_stall_ls", 32'(o0_sls), 0);
    repeat (3) begin adv(); smp(); end
    adv(); if_req_i = 1'b1; if_addr_i = 13'h018; smp();
    chk("r_regrant", 32'(o0_if_gnt), 1);
    adv(); if_req_i = 1'b0;
    repeat (3) begin smp(); adv(); end
    chk("r_drained", 32'(q.size()), 0);

    // Lat=1 back-to-back fetches on u1
    rst_i = 1'b1; adv(); rst_i = 1'b0; use1 = 1'b1; q.delete();
    adv(); if_req_i = 1'b1; if_addr_i = 13'h010; smp();
    chk("l1_gnt_T", 32'(o1_if_gnt), 1);
    adv(); if_addr_i = 13'h014; smp();
    chk("l1_gnt_T1", 32'(o1_if_gnt), 0);  chk("l1_stall_T1", 32'(o1_sif), 1);
    adv(); smp();
    chk("l1_rv_T2", 32'(o1_if_rv), 1);    chk("l1_rd_T2", o1_if_rd, 32'h00500093);
    chk("l1_gnt_T2", 32'(o1_if_gnt), 1);
    adv(); if_req_i = 1'b0; smp();
    chk("l1_rv_T3", 32'(o1_if_rv), 0);
    adv(); smp();
    chk("l1_rv_T4", 32'(o1_if_rv), 1);    chk("l1_rd_T4", o1_if_rd, memval(13'h014));
    adv(); smp();
    chk("final_queue_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
